// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl: interrupt/reset sequencer for the 2A03 core.
// Picks RESET/NMI/BRK/IRQ at instruction boundaries, pushes PC and P, then loads PC from the vector.
//
// state  | meaning
// IDLE   | waiting for a pending event (RESET needs no boundary)
// PUSH_H | push PC high byte to 0x01SP
// PUSH_L | push PC low byte to 0x01SP
// PUSH_P | push status, B set only for BRK
// VEC_L  | read vector low byte into PCL
// VEC_H  | read vector high byte into PCH, set I, finish
module int_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        boundary,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        brk_req,
    input  logic        i_flag,
    input  logic [7:0]  p_cur,
    input  logic [7:0]  pcl_cur,
    input  logic [7:0]  pch_cur,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        sp_dec,
    output logic        load_pc_l,
    output logic        load_pc_h,
    output logic [7:0]  pcl_load_val,
    output logic [7:0]  pch_load_val,
    output logic        set_i,
    output logic        busy,
    output logic        int_done
);
    typedef enum logic [2:0] {IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H} state_t;
    typedef enum logic [1:0] {K_RES, K_NMI, K_BRK, K_IRQ} kind_t;

    state_t      state, state_nxt;
    kind_t       kind, kind_nxt;
    logic        res_pend, nmi_pend, nmi_q;
    logic        nmi_edge, irq_act, start;
    logic [15:0] vec_base;

    assign nmi_edge = nmi_q & ~nmi_n;
    assign irq_act  = ~irq_n & ~i_flag;
    assign start    = (state == IDLE) && (state_nxt != IDLE);

    always_ff @(posedge clk) begin
        // the NMI sampler keeps running through reset so a line held low across reset is not an edge
        nmi_q <= nmi_n;
        if (rst) begin
            state    <= IDLE;
            kind     <= K_RES;
            res_pend <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            kind  <= kind_nxt;
            if (start && kind_nxt == K_RES)
                res_pend <= 1'b0;
            if (nmi_edge)
                nmi_pend <= 1'b1;
            else if (start && kind_nxt == K_NMI)
                nmi_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        case (state)
            IDLE: begin
                if (res_pend) begin
                    state_nxt = PUSH_H;
                    kind_nxt  = K_RES;
                end else if (boundary && nmi_pend) begin
                    state_nxt = PUSH_H;
                    kind_nxt  = K_NMI;
                end else if (boundary && brk_req) begin
                    state_nxt = PUSH_H;
                    kind_nxt  = K_BRK;
                end else if (boundary && irq_act) begin
                    state_nxt = PUSH_H;
                    kind_nxt  = K_IRQ;
                end
            end
            PUSH_H:  state_nxt = PUSH_L;
            PUSH_L:  state_nxt = PUSH_P;
            PUSH_P:  state_nxt = VEC_L;
            VEC_L:   state_nxt = VEC_H;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (kind)
            K_NMI:   vec_base = 16'hFFFA;
            K_RES:   vec_base = 16'hFFFC;
            default: vec_base = 16'hFFFE;
        endcase
    end

    // outputs are forced quiet while rst is high, even though the state register only clears at the edge
    always_comb begin
        mem_addr     = 16'h0000;
        mem_wdata    = 8'h00;
        mem_we       = 1'b0;
        sp_dec       = 1'b0;
        load_pc_l    = 1'b0;
        load_pc_h    = 1'b0;
        pcl_load_val = 8'h00;
        pch_load_val = 8'h00;
        set_i        = 1'b0;
        busy         = 1'b0;
        int_done     = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                PUSH_H, PUSH_L, PUSH_P: begin
                    mem_addr = {8'h01, sp_in};
                    sp_dec   = 1'b1;
                    mem_we   = (kind != K_RES);
                    if (state == PUSH_H)
                        mem_wdata = pch_cur;
                    else if (state == PUSH_L)
                        mem_wdata = pcl_cur;
                    else
                        mem_wdata = {p_cur[7:6], 1'b1, kind == K_BRK, p_cur[3:0]};
                end
                VEC_L: begin
                    mem_addr     = vec_base;
                    load_pc_l    = 1'b1;
                    pcl_load_val = mem_rdata;
                end
                VEC_H: begin
                    mem_addr     = {vec_base[15:1], 1'b1};
                    load_pc_h    = 1'b1;
                    pch_load_val = mem_rdata;
                    set_i        = 1'b1;
                    int_done     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_int_seq_ctrl.sv
// Bench for int_seq_ctrl: a small 6502-like core (SP, PC, I flag, memory) around the DUT,
// a queue-based reference of the expected bus cycles, directed cases and a random run.
module tb_int_seq_ctrl;
    localparam int K_RES = 0, K_NMI = 1, K_BRK = 2, K_IRQ = 3;

    logic        clk = 1'b0;
    logic        rst, boundary, nmi_n, irq_n, brk_req, i_flag;
    logic [7:0]  p_cur, pcl_cur, pch_cur, sp_in, mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, pcl_load_val, pch_load_val;
    logic        mem_we, sp_dec, load_pc_l, load_pc_h, set_i, busy, int_done;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;

    assign pcl_cur   = pc[7:0];
    assign pch_cur   = pc[15:8];
    assign mem_rdata = mem[mem_addr];

    int_seq_ctrl dut (
        .clk(clk), .rst(rst), .boundary(boundary), .nmi_n(nmi_n), .irq_n(irq_n),
        .brk_req(brk_req), .i_flag(i_flag), .p_cur(p_cur), .pcl_cur(pcl_cur),
        .pch_cur(pch_cur), .sp_in(sp_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .sp_dec(sp_dec), .load_pc_l(load_pc_l),
        .load_pc_h(load_pc_h), .pcl_load_val(pcl_load_val), .pch_load_val(pch_load_val),
        .set_i(set_i), .busy(busy), .int_done(int_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int kind;
    } ent_t;

    ent_t        mq[$];
    bit          m_res, m_nmi;
    logic        m_nprev;

    int          total, bad, cyc, done_at, r_cyc;
    int          n_spd, n_we, n_busy, n_done, n_seti, n_ld;
    bit          done_flag;
    logic [15:0] aq[$];
    logic [15:0] s_addr;
    logic [7:0]  s_wd, s_pl, s_ph;
    logic        s_we, s_spd, s_ll, s_lh, s_si;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic start_seq(input int k);
        ent_t e;
        for (int s = 0; s < 5; s++) begin
            e.step = s;
            e.kind = k;
            mq.push_back(e);
        end
    endtask

    task automatic model_step();
        logic edge_n;
        edge_n  = m_nprev & ~nmi_n;
        m_nprev = nmi_n;
        if (rst) begin
            mq.delete();
            m_res = 1'b1;
            m_nmi = 1'b0;
        end else begin
            if (mq.size() > 0)
                mq.delete(0);
            else if (m_res) begin
                start_seq(K_RES);
                m_res = 1'b0;
            end else if (boundary) begin
                if (m_nmi) begin
                    start_seq(K_NMI);
                    m_nmi = 1'b0;
                end else if (brk_req)
                    start_seq(K_BRK);
                else if (!irq_n && !i_flag)
                    start_seq(K_IRQ);
            end
            if (edge_n)
                m_nmi = 1'b1;
        end
    endtask

    task automatic compare();
        logic [15:0] ea, base;
        logic [7:0]  ew, epl, eph;
        logic        ewe, esd, ell, elh, esi, eb, ed;
        int          st, kd;
        ea = 0; ew = 0; epl = 0; eph = 0; base = 0;
        ewe = 0; esd = 0; ell = 0; elh = 0; esi = 0; eb = 0; ed = 0;
        cyc++;
        if (!rst && mq.size() > 0) begin
            st   = mq[0].step;
            kd   = mq[0].kind;
            base = (kd == K_NMI) ? 16'hFFFA : (kd == K_RES) ? 16'hFFFC : 16'hFFFE;
            eb   = 1'b1;
            if (st < 3) begin
                ea  = 16'h0100 + {8'h00, sp_in};
                esd = 1'b1;
                ewe = (kd != K_RES);
                if (st == 0)      ew = pch_cur;
                else if (st == 1) ew = pcl_cur;
                else              ew = (p_cur & 8'hEF) | 8'h20 | ((kd == K_BRK) ? 8'h10 : 8'h00);
            end else if (st == 3) begin
                ea  = base;
                ell = 1'b1;
                epl = mem[base];
            end else begin
                ea  = base + 16'd1;
                elh = 1'b1;
                eph = mem[base + 16'd1];
                esi = 1'b1;
                ed  = 1'b1;
            end
        end
        chk("busy", busy, eb);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("mem_we", mem_we, ewe);
        chk("sp_dec", sp_dec, esd);
        chk("load_pc_l", load_pc_l, ell);
        chk("load_pc_h", load_pc_h, elh);
        chk("pcl_load_val", pcl_load_val, epl);
        chk("pch_load_val", pch_load_val, eph);
        chk("set_i", set_i, esi);
        chk("int_done", int_done, ed);
        if (busy === 1'b1) begin
            n_busy++;
            aq.push_back(mem_addr);
        end
        if (sp_dec === 1'b1) n_spd++;
        if (mem_we === 1'b1) n_we++;
        if (set_i === 1'b1) n_seti++;
        if (load_pc_l === 1'b1 || load_pc_h === 1'b1) n_ld++;
        if (int_done === 1'b1) begin
            n_done++;
            done_flag = 1'b1;
            done_at   = cyc;
        end
        s_addr = mem_addr; s_wd = mem_wdata; s_we = mem_we; s_spd = sp_dec;
        s_ll = load_pc_l; s_lh = load_pc_h; s_pl = pcl_load_val; s_ph = pch_load_val; s_si = set_i;
    endtask

    task automatic apply_core();
        if (s_we === 1'b1) mem[s_addr] = s_wd;
        if (s_spd === 1'b1) sp_in = sp_in - 8'd1;
        if (s_ll === 1'b1) pc[7:0] = s_pl;
        if (s_lh === 1'b1) pc[15:8] = s_ph;
        if (s_si === 1'b1) i_flag = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
        apply_core();
    endtask

    task automatic clear_acc();
        n_spd = 0; n_we = 0; n_busy = 0; n_done = 0; n_seti = 0; n_ld = 0;
        done_flag = 1'b0; done_at = -1;
        aq.delete();
    endtask

    task automatic run_until_done(input string nm, input int lim);
        for (int i = 0; i < lim && !done_flag; i++)
            cycle();
        if (!done_flag) begin
            total++;
            bad++;
            $display("FAIL %s: no int_done within %0d cycles", nm, lim);
        end
    endtask

    function automatic logic [15:0] aq_at(input int idx);
        return (idx < aq.size()) ? aq[idx] : 16'hxxxx;
    endfunction

    initial begin
        logic [15:0] exp_a [5];
        total = 0; bad = 0; cyc = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        rst = 1'b1; boundary = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0;
        i_flag = 1'b1; p_cur = 8'h00; pc = 16'h0000; sp_in = 8'hFD;
        m_res = 1'b1; m_nmi = 1'b0; m_nprev = 1'b1;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
        clear_acc();

        // power-on reset: rst high for two edges, dummy pushes then vector 0xFFFC
        @(posedge clk);
        model_step();
        #1;
        cycle();
        rst = 1'b0;
        clear_acc();
        r_cyc = cyc + 1;
        run_until_done("reset_seq", 12);
        chk("reset_done_cycle", done_at, r_cyc + 5);
        chk("reset_spdec_count", n_spd, 3);
        chk("reset_we_count", n_we, 0);
        chk("reset_seti_count", n_seti, 1);
        chk("reset_pc", pc, 16'hC000);
        chk("reset_sp", sp_in, 8'hFA);
        exp_a[0] = 16'h01FD; exp_a[1] = 16'h01FC; exp_a[2] = 16'h01FB;
        exp_a[3] = 16'hFFFC; exp_a[4] = 16'hFFFD;
        for (int i = 0; i < 5; i++)
            chk($sformatf("reset_addr%0d", i), aq_at(i), exp_a[i]);

        // unmasked IRQ
        sp_in = 8'hFF; pc = 16'h1234; p_cur = 8'h00; i_flag = 1'b0; irq_n = 1'b0;
        mem[16'hFFFE] = 8'h78; mem[16'hFFFF] = 8'h56;
        clear_acc();
        boundary = 1'b1;
        cycle();
        boundary = 1'b0;
        run_until_done("irq_seq", 10);
        irq_n = 1'b1;
        chk("irq_push_pch", mem[16'h01FF], 8'h12);
        chk("irq_push_pcl", mem[16'h01FE], 8'h34);
        chk("irq_push_p", mem[16'h01FD], 8'h20);
        chk("irq_pc", pc, 16'h5678);
        chk("irq_busy_cycles", n_busy, 5);
        chk("irq_sp", sp_in, 8'hFC);
        chk("irq_i_set", i_flag, 1'b1);

        // masked IRQ: nothing happens
        i_flag = 1'b1; irq_n = 1'b0;
        clear_acc();
        for (int i = 0; i < 10; i++) begin
            boundary = 1'b1;
            cycle();
        end
        boundary = 1'b0; irq_n = 1'b1;
        chk("masked_busy", n_busy, 0);
        chk("masked_strobes", n_spd + n_we + n_ld + n_seti, 0);

        // NMI and IRQ together, then NMI held low with repeated boundaries
        sp_in = 8'hFF; pc = 16'h2222; p_cur = 8'h00; i_flag = 1'b0; irq_n = 1'b0;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        clear_acc();
        nmi_n = 1'b0;
        cycle();
        boundary = 1'b1;
        for (int i = 0; i < 25; i++) cycle();
        boundary = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
        chk("nmi_done_count", n_done, 1);
        chk("nmi_pc", pc, 16'h9000);
        chk("nmi_push_p", mem[16'h01FD], 8'h20);
        chk("nmi_vec_addr", aq_at(3), 16'hFFFA);
        cycle();

        // BRK
        sp_in = 8'hFF; pc = 16'h4002; p_cur = 8'h00; i_flag = 1'b1;
        mem[16'hFFFE] = 8'hAB; mem[16'hFFFF] = 8'hCD;
        clear_acc();
        brk_req = 1'b1; boundary = 1'b1;
        cycle();
        brk_req = 1'b0; boundary = 1'b0;
        run_until_done("brk_seq", 10);
        chk("brk_push_p", mem[16'h01FD], 8'h30);
        chk("brk_push_pch", mem[16'h01FF], 8'h40);
        chk("brk_pc", pc, 16'hCDAB);
        chk("brk_vec_addr", aq_at(3), 16'hFFFE);
        chk("brk_we_count", n_we, 3);

        // reset during PUSH_L of an IRQ
        sp_in = 8'hFF; pc = 16'h1234; i_flag = 1'b0; irq_n = 1'b0;
        boundary = 1'b1;
        cycle();
        boundary = 1'b0;
        cycle();
        rst = 1'b1;
        clear_acc();
        cycle();
        rst = 1'b0; irq_n = 1'b1;
        run_until_done("rst_mid_seq", 12);
        chk("rst_mid_we_count", n_we, 0);
        chk("rst_mid_vec_addr", aq_at(3), 16'hFFFC);
        chk("rst_mid_pc", pc, 16'hC000);
        chk("rst_mid_done_count", n_done, 1);

        // random traffic against the reference
        for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            boundary = ($urandom_range(0, 2) == 0);
            brk_req  = boundary && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0)  irq_n = ~irq_n;
            if ($urandom_range(0, 14) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 19) == 0) i_flag = 1'b0;
            if ($urandom_range(0, 7) == 0)  pc = 16'($urandom);
            p_cur = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
